// File: rtl/alu_exec_queue.sv
// Integer/branch execution stage: computes one result per cycle and buffers it in a small
// result FIFO until the CDB accepts it; look-ahead backpressure to the RS, flush on rollback.
module alu_exec_queue #(
  parameter int unsigned OP_W        = 6,
  parameter int unsigned ROB_POS_W   = 5,
  parameter int unsigned QUEUE_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rdy,
  input  logic                 rollback,
  input  logic                 alu_enable,
  input  logic [OP_W-1:0]      alu_openum,
  input  logic [ROB_POS_W-1:0] alu_rob_pos,
  input  logic [31:0]          alu_rs1_val,
  input  logic [31:0]          alu_rs2_val,
  input  logic [31:0]          alu_imm,
  input  logic [31:0]          alu_pc,
  output logic                 alu_next_full,
  output logic                 res_valid,
  input  logic                 res_ack,
  output logic [ROB_POS_W-1:0] res_rob_pos,
  output logic [31:0]          res_val,
  output logic                 res_jump,
  output logic [31:0]          res_target
);

  localparam int unsigned PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH + 1);

  localparam logic [OP_W-1:0] OP_LUI   = OP_W'(1);
  localparam logic [OP_W-1:0] OP_AUIPC = OP_W'(2);
  localparam logic [OP_W-1:0] OP_JAL   = OP_W'(3);
  localparam logic [OP_W-1:0] OP_JALR  = OP_W'(4);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(5);
  localparam logic [OP_W-1:0] OP_BNE   = OP_W'(6);
  localparam logic [OP_W-1:0] OP_BLT   = OP_W'(7);
  localparam logic [OP_W-1:0] OP_BGE   = OP_W'(8);
  localparam logic [OP_W-1:0] OP_BLTU  = OP_W'(9);
  localparam logic [OP_W-1:0] OP_BGEU  = OP_W'(10);
  localparam logic [OP_W-1:0] OP_ADD   = OP_W'(11);
  localparam logic [OP_W-1:0] OP_SUB   = OP_W'(12);
  localparam logic [OP_W-1:0] OP_AND   = OP_W'(13);
  localparam logic [OP_W-1:0] OP_OR    = OP_W'(14);
  localparam logic [OP_W-1:0] OP_XOR   = OP_W'(15);
  localparam logic [OP_W-1:0] OP_SLL   = OP_W'(16);
  localparam logic [OP_W-1:0] OP_SRL   = OP_W'(17);
  localparam logic [OP_W-1:0] OP_SRA   = OP_W'(18);
  localparam logic [OP_W-1:0] OP_SLT   = OP_W'(19);
  localparam logic [OP_W-1:0] OP_SLTU  = OP_W'(20);
  localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(21);
  localparam logic [OP_W-1:0] OP_ANDI  = OP_W'(22);
  localparam logic [OP_W-1:0] OP_ORI   = OP_W'(23);
  localparam logic [OP_W-1:0] OP_XORI  = OP_W'(24);
  localparam logic [OP_W-1:0] OP_SLLI  = OP_W'(25);
  localparam logic [OP_W-1:0] OP_SRLI  = OP_W'(26);
  localparam logic [OP_W-1:0] OP_SRAI  = OP_W'(27);
  localparam logic [OP_W-1:0] OP_SLTI  = OP_W'(28);
  localparam logic [OP_W-1:0] OP_SLTIU = OP_W'(29);

  logic [ROB_POS_W-1:0] mem_rob    [QUEUE_DEPTH];
  logic [31:0]          mem_val    [QUEUE_DEPTH];
  logic                 mem_jump   [QUEUE_DEPTH];
  logic [31:0]          mem_target [QUEUE_DEPTH];

  logic [PTR_W-1:0] rd_ptr, wr_ptr, rd_ptr_nxt, wr_ptr_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic             push, pop;

  logic [31:0] op2, c_val, c_target;
  logic        c_jump, imm_form;
  logic [4:0]  shamt;

  logic                 valid_nxt, next_full_nxt, jump_nxt;
  logic [ROB_POS_W-1:0] rob_nxt;
  logic [31:0]          val_nxt, target_nxt;

  // Result compute: purely combinational from the dispatched bundle
  always_comb begin
    imm_form = 1'b0;
    case (alu_openum)
      OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLLI,
      OP_SRLI, OP_SRAI, OP_SLTI, OP_SLTIU: imm_form = 1'b1;
      default:                             imm_form = 1'b0;
    endcase
    op2      = imm_form ? alu_imm : alu_rs2_val;
    shamt    = op2[4:0];
    c_val    = 32'd0;
    c_jump   = 1'b0;
    c_target = 32'd0;
    case (alu_openum)
      OP_LUI:   c_val = alu_imm;
      OP_AUIPC: c_val = alu_pc + alu_imm;
      OP_JAL: begin
        c_val    = alu_pc + 32'd4;
        c_jump   = 1'b1;
        c_target = alu_pc + alu_imm;
      end
      OP_JALR: begin
        c_val    = alu_pc + 32'd4;
        c_jump   = 1'b1;
        c_target = (alu_rs1_val + alu_imm) & ~32'd1;
      end
      OP_BEQ:  begin c_jump = (alu_rs1_val == alu_rs2_val); c_target = alu_pc + alu_imm; end
      OP_BNE:  begin c_jump = (alu_rs1_val != alu_rs2_val); c_target = alu_pc + alu_imm; end
      OP_BLT:  begin c_jump = ($signed(alu_rs1_val) <  $signed(alu_rs2_val)); c_target = alu_pc + alu_imm; end
      OP_BGE:  begin c_jump = ($signed(alu_rs1_val) >= $signed(alu_rs2_val)); c_target = alu_pc + alu_imm; end
      OP_BLTU: begin c_jump = (alu_rs1_val <  alu_rs2_val); c_target = alu_pc + alu_imm; end
      OP_BGEU: begin c_jump = (alu_rs1_val >= alu_rs2_val); c_target = alu_pc + alu_imm; end
      OP_ADD, OP_ADDI:   c_val = alu_rs1_val + op2;
      OP_SUB:            c_val = alu_rs1_val - op2;
      OP_AND, OP_ANDI:   c_val = alu_rs1_val & op2;
      OP_OR,  OP_ORI:    c_val = alu_rs1_val | op2;
      OP_XOR, OP_XORI:   c_val = alu_rs1_val ^ op2;
      OP_SLL, OP_SLLI:   c_val = alu_rs1_val << shamt;
      OP_SRL, OP_SRLI:   c_val = alu_rs1_val >> shamt;
      OP_SRA, OP_SRAI:   c_val = 32'($signed(alu_rs1_val) >>> shamt);
      OP_SLT, OP_SLTI:   c_val = {31'd0, $signed(alu_rs1_val) < $signed(op2)};
      OP_SLTU, OP_SLTIU: c_val = {31'd0, alu_rs1_val < op2};
      default: ;
    endcase
  end

  // FIFO control and next head view; the head comes from the push path when the queue drains to it
  always_comb begin
    pop           = rdy & ~rollback & res_valid & res_ack;
    push          = rdy & ~rollback & alu_enable & ((count != CNT_W'(QUEUE_DEPTH)) | pop);
    count_nxt     = count + CNT_W'(push) - CNT_W'(pop);
    rd_ptr_nxt    = pop  ? rd_ptr + PTR_W'(1) : rd_ptr;
    wr_ptr_nxt    = push ? wr_ptr + PTR_W'(1) : wr_ptr;
    valid_nxt     = 1'b0;
    rob_nxt       = '0;
    val_nxt       = 32'd0;
    jump_nxt      = 1'b0;
    target_nxt    = 32'd0;
    if (rdy && rollback) begin
      count_nxt  = '0;
      rd_ptr_nxt = '0;
      wr_ptr_nxt = '0;
    end
    if (count_nxt != '0) begin
      valid_nxt = 1'b1;
      if (push && (count == CNT_W'(pop))) begin
        rob_nxt    = alu_rob_pos;
        val_nxt    = c_val;
        jump_nxt   = c_jump;
        target_nxt = c_target;
      end else begin
        rob_nxt    = mem_rob[rd_ptr_nxt];
        val_nxt    = mem_val[rd_ptr_nxt];
        jump_nxt   = mem_jump[rd_ptr_nxt];
        target_nxt = mem_target[rd_ptr_nxt];
      end
    end
    next_full_nxt = (count_nxt >= CNT_W'(QUEUE_DEPTH - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
      res_valid     <= 1'b0;
      res_rob_pos   <= '0;
      res_val       <= 32'd0;
      res_jump      <= 1'b0;
      res_target    <= 32'd0;
      alu_next_full <= 1'b0;
    end else if (rdy) begin
      rd_ptr        <= rd_ptr_nxt;
      wr_ptr        <= wr_ptr_nxt;
      count         <= count_nxt;
      res_valid     <= valid_nxt;
      res_rob_pos   <= rob_nxt;
      res_val       <= val_nxt;
      res_jump      <= jump_nxt;
      res_target    <= target_nxt;
      alu_next_full <= next_full_nxt;
    end
  end

  // Storage carries no reset; validity is tracked by count alone
  always_ff @(posedge clk) begin
    if (push) begin
      mem_rob[wr_ptr]    <= alu_rob_pos;
      mem_val[wr_ptr]    <= c_val;
      mem_jump[wr_ptr]   <= c_jump;
      mem_target[wr_ptr] <= c_target;
    end
  end

  overflow_a: assert property (@(posedge clk) disable iff (!rst_n)
    !(rdy && !rollback && alu_enable && (count == CNT_W'(QUEUE_DEPTH)) && !pop));

endmodule

// File: tb/tb_alu_exec_queue.sv
// Directed bench for alu_exec_queue: compute vectors, FIFO ordering/backpressure, rollback,
// rdy freeze and asynchronous reset.
module tb_alu_exec_queue;

  localparam logic [5:0] OP_LUI = 6'd1, OP_AUIPC = 6'd2, OP_JAL = 6'd3, OP_JALR = 6'd4;
  localparam logic [5:0] OP_BEQ = 6'd5, OP_BLTU = 6'd9, OP_ADD = 6'd11, OP_SUB = 6'd12;
  localparam logic [5:0] OP_XOR = 6'd15, OP_SRA = 6'd18, OP_SLT = 6'd19, OP_SLTU = 6'd20;
  localparam logic [5:0] OP_ADDI = 6'd21, OP_SLLI = 6'd25, OP_BAD = 6'd63;

  logic        clk = 1'b0;
  logic        rst_n, rdy, rollback, alu_enable, res_ack;
  logic [5:0]  alu_openum;
  logic [4:0]  alu_rob_pos;
  logic [31:0] alu_rs1_val, alu_rs2_val, alu_imm, alu_pc;
  logic        alu_next_full, res_valid, res_jump;
  logic [4:0]  res_rob_pos;
  logic [31:0] res_val, res_target;

  int n_checks = 0;
  int n_pass   = 0;

  alu_exec_queue #(.OP_W(6), .ROB_POS_W(5), .QUEUE_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .rollback(rollback),
    .alu_enable(alu_enable), .alu_openum(alu_openum), .alu_rob_pos(alu_rob_pos),
    .alu_rs1_val(alu_rs1_val), .alu_rs2_val(alu_rs2_val), .alu_imm(alu_imm), .alu_pc(alu_pc),
    .alu_next_full(alu_next_full), .res_valid(res_valid), .res_ack(res_ack),
    .res_rob_pos(res_rob_pos), .res_val(res_val), .res_jump(res_jump), .res_target(res_target)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction for a single cycle, then withdraw alu_enable
  task automatic issue(input logic [5:0] op, input logic [4:0] tag, input logic [31:0] rs1,
                       input logic [31:0] rs2, input logic [31:0] imm, input logic [31:0] pc);
    alu_openum  = op;
    alu_rob_pos = tag;
    alu_rs1_val = rs1;
    alu_rs2_val = rs2;
    alu_imm     = imm;
    alu_pc      = pc;
    alu_enable  = 1'b1;
    step();
    alu_enable  = 1'b0;
  endtask

  task automatic exec_chk(input string tag, input logic [5:0] op, input logic [31:0] rs1,
                          input logic [31:0] rs2, input logic [31:0] imm, input logic [31:0] pc,
                          input logic [31:0] exp_val, input logic exp_jump,
                          input logic [31:0] exp_target);
    issue(op, 5'd1, rs1, rs2, imm, pc);
    chk({tag, ".valid"},  32'(res_valid),   32'd1);
    chk({tag, ".val"},    res_val,          exp_val);
    chk({tag, ".jump"},   32'(res_jump),    32'(exp_jump));
    chk({tag, ".target"}, res_target,       exp_target);
  endtask

  initial begin
    rst_n = 1'b0; rdy = 1'b1; rollback = 1'b0; alu_enable = 1'b0; res_ack = 1'b1;
    alu_openum = '0; alu_rob_pos = '0; alu_rs1_val = '0; alu_rs2_val = '0;
    alu_imm = '0; alu_pc = '0;
    #2;
    chk("rst.valid",     32'(res_valid),     32'd0);
    chk("rst.rob",       32'(res_rob_pos),   32'd0);
    chk("rst.val",       res_val,            32'd0);
    chk("rst.next_full", 32'(alu_next_full), 32'd0);
    step(); step();
    rst_n = 1'b1;
    step();

    issue(OP_ADDI, 5'd3, 32'd5, 32'd0, 32'hFFFF_FFFD, 32'd0);
    chk("addi.valid", 32'(res_valid),   32'd1);
    chk("addi.val",   res_val,          32'd2);
    chk("addi.rob",   32'(res_rob_pos), 32'd3);
    chk("addi.jump",  32'(res_jump),    32'd0);

    exec_chk("jalr",  OP_JALR,  32'h2001, 0, 32'd4, 32'h100, 32'h104, 1'b1, 32'h2004);
    exec_chk("bltu",  OP_BLTU,  32'd1, 32'hFFFF_FFFF, 32'h10, 32'h200, 32'd0, 1'b1, 32'h210);
    exec_chk("beq",   OP_BEQ,   32'd7, 32'd8, 32'h10, 32'h200, 32'd0, 1'b0, 32'h210);
    exec_chk("sra",   OP_SRA,   32'h8000_0000, 32'h21, 0, 0, 32'hC000_0000, 1'b0, 32'd0);
    exec_chk("slt",   OP_SLT,   32'hFFFF_FFFF, 32'd1, 0, 0, 32'd1, 1'b0, 32'd0);
    exec_chk("sltu",  OP_SLTU,  32'hFFFF_FFFF, 32'd1, 0, 0, 32'd0, 1'b0, 32'd0);
    exec_chk("sub",   OP_SUB,   32'd3, 32'd5, 0, 0, 32'hFFFF_FFFE, 1'b0, 32'd0);
    exec_chk("xor",   OP_XOR,   32'hF0F0_F0F0, 32'hFF00_FF00, 0, 0, 32'h0FF0_0FF0, 1'b0, 32'd0);
    exec_chk("add",   OP_ADD,   32'hFFFF_FFFF, 32'd2, 32'd100, 0, 32'd1, 1'b0, 32'd0);
    exec_chk("lui",   OP_LUI,   32'd9, 32'd9, 32'h1234_5000, 32'h40, 32'h1234_5000, 1'b0, 32'd0);
    exec_chk("auipc", OP_AUIPC, 0, 0, 32'h20, 32'h1000, 32'h1020, 1'b0, 32'd0);
    exec_chk("jal",   OP_JAL,   0, 0, 32'hFFFF_FFF8, 32'h40, 32'h44, 1'b1, 32'h38);
    exec_chk("slli",  OP_SLLI,  32'd1, 32'd0, 32'd31, 0, 32'h8000_0000, 1'b0, 32'd0);
    exec_chk("unk",   OP_BAD,   32'd5, 32'd6, 32'd7, 32'h80, 32'd0, 1'b0, 32'd0);
    step();
    chk("drain.valid", 32'(res_valid), 32'd0);

    // Backpressure: three queued entries raise next_full, the in-flight fourth still fits
    res_ack = 1'b0;
    issue(OP_ADDI, 5'd4, 32'd40, 0, 0, 0);
    chk("q1.next_full", 32'(alu_next_full), 32'd0);
    issue(OP_ADDI, 5'd5, 32'd50, 0, 0, 0);
    chk("q2.next_full", 32'(alu_next_full), 32'd0);
    issue(OP_ADDI, 5'd6, 32'd60, 0, 0, 0);
    chk("q3.next_full", 32'(alu_next_full), 32'd1);
    issue(OP_ADDI, 5'd7, 32'd70, 0, 0, 0);
    chk("q4.next_full", 32'(alu_next_full), 32'd1);
    chk("q4.head_rob",  32'(res_rob_pos),   32'd4);
    chk("q4.head_val",  res_val,            32'd40);

    // Push and pop together while full
    res_ack = 1'b1;
    issue(OP_ADDI, 5'd8, 32'd80, 0, 0, 0);
    chk("full_pp.head_rob",  32'(res_rob_pos),   32'd5);
    chk("full_pp.next_full", 32'(alu_next_full), 32'd1);
    step();
    chk("drain.rob6", 32'(res_rob_pos), 32'd6);
    step();
    chk("drain.rob7", 32'(res_rob_pos), 32'd7);
    step();
    chk("drain.rob8", 32'(res_rob_pos), 32'd8);
    chk("drain.val8", res_val,          32'd80);
    step();
    chk("drain.empty",     32'(res_valid),     32'd0);
    chk("drain.next_full", 32'(alu_next_full), 32'd0);

    // Rollback with a same-cycle dispatch
    res_ack = 1'b0;
    issue(OP_ADDI, 5'd9,  32'd1, 0, 0, 0);
    issue(OP_ADDI, 5'd10, 32'd2, 0, 0, 0);
    chk("rb.pre_valid", 32'(res_valid), 32'd1);
    rollback = 1'b1;
    issue(OP_ADDI, 5'd11, 32'd3, 0, 0, 0);
    rollback = 1'b0;
    chk("rb.valid",     32'(res_valid),     32'd0);
    chk("rb.next_full", 32'(alu_next_full), 32'd0);
    step();
    chk("rb.after_valid", 32'(res_valid), 32'd0);

    // rdy low: dispatch lost, head held despite ack
    rdy = 1'b0;
    issue(OP_ADDI, 5'd12, 32'd1, 0, 0, 0);
    chk("rdy0.no_push", 32'(res_valid), 32'd0);
    rdy = 1'b1;
    issue(OP_ADDI, 5'd13, 32'd13, 0, 0, 0);
    chk("rdy1.rob", 32'(res_rob_pos), 32'd13);
    rdy = 1'b0; res_ack = 1'b1;
    step();
    chk("rdy0.hold_valid", 32'(res_valid),   32'd1);
    chk("rdy0.hold_rob",   32'(res_rob_pos), 32'd13);
    rdy = 1'b1;
    step();
    chk("rdy1.popped", 32'(res_valid), 32'd0);

    // Asynchronous reset between clock edges
    res_ack = 1'b0;
    issue(OP_ADDI, 5'd14, 32'd14, 0, 0, 0);
    issue(OP_ADDI, 5'd15, 32'd15, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.valid",     32'(res_valid),     32'd0);
    chk("arst.rob",       32'(res_rob_pos),   32'd0);
    chk("arst.val",       res_val,            32'd0);
    chk("arst.next_full", 32'(alu_next_full), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("arst.stay_empty", 32'(res_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
